// File: rtl/spi_master.sv
// spi_master: SPI mode-0 initiator with a word-level valid/ready host interface.
// sclk, ssel and mosi come straight from flops. Back-to-back words keep ssel low.
// Optional macro SPI_MASTER_LSB_FIRST_EN: LSB-first on mosi and on rxData.
module spi_master #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] txData,
    input  logic                  txValid,
    output logic                  txReady,
    output logic [DATA_WIDTH-1:0] rxData,
    output logic                  rxValid,
    output logic                  busy,
    output logic                  sclk,
    output logic                  ssel,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH);

    if (DATA_WIDTH < 2) begin : g_bad_width
        $error("spi_master: DATA_WIDTH must be at least 2");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("spi_master: CLK_DIV must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_WORD_END,
        ST_HOLD,
        ST_DESEL
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DIV_W-1:0]      r_div_cnt,  w_div_cnt_nxt;
    logic [BIT_W-1:0]      r_bit_cnt,  w_bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_tx_shift, w_tx_shift_nxt;
    logic [DATA_WIDTH-1:0] r_rx_shift, w_rx_shift_nxt;
    logic [DATA_WIDTH-1:0] r_rx_data,  w_rx_data_nxt;
    logic                  r_rx_valid, w_rx_valid_nxt;
    logic                  r_tx_ready, w_tx_ready_nxt;
    logic                  r_busy,     w_busy_nxt;
    logic                  r_sclk,     w_sclk_nxt;
    logic                  r_ssel,     w_ssel_nxt;
    logic                  r_mosi,     w_mosi_nxt;

    logic                  w_tick;
    logic                  w_accept;
    logic                  w_load_bit;
    logic                  w_next_bit;
    logic [DATA_WIDTH-1:0] w_tx_shifted;
    logic [DATA_WIDTH-1:0] w_rx_shifted;

    assign w_tick   = (r_div_cnt == DIV_LAST);
    assign w_accept = txValid & r_tx_ready;

    // Bit-order selection; the tx register rotates so every stored bit stays live.
`ifdef SPI_MASTER_LSB_FIRST_EN
    assign w_load_bit   = txData[0];
    assign w_tx_shifted = {r_tx_shift[0], r_tx_shift[DATA_WIDTH-1:1]};
    assign w_next_bit   = r_tx_shift[1];
    assign w_rx_shifted = {miso, r_rx_shift[DATA_WIDTH-1:1]};
`else
    assign w_load_bit   = txData[DATA_WIDTH-1];
    assign w_tx_shifted = {r_tx_shift[DATA_WIDTH-2:0], r_tx_shift[DATA_WIDTH-1]};
    assign w_next_bit   = r_tx_shift[DATA_WIDTH-2];
    assign w_rx_shifted = {r_rx_shift[DATA_WIDTH-2:0], miso};
`endif

    // State register; reset aborts any transfer in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (w_accept) w_state_nxt = ST_SETUP;
            ST_SETUP:    if (w_tick) w_state_nxt = ST_SHIFT;
            ST_SHIFT:    if (w_tick && r_sclk && (r_bit_cnt == BIT_LAST)) w_state_nxt = ST_WORD_END;
            ST_WORD_END: w_state_nxt = w_accept ? ST_SETUP : ST_HOLD;
            ST_HOLD:     if (w_tick) w_state_nxt = ST_DESEL;
            ST_DESEL:    if (w_tick) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // Output/datapath next values: divider, shifters, SPI pins and host handshake.
    always_comb begin
        w_div_cnt_nxt  = ((w_state_nxt != r_state) || w_tick) ? '0 : r_div_cnt + DIV_W'(1);
        w_bit_cnt_nxt  = r_bit_cnt;
        w_tx_shift_nxt = r_tx_shift;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_tx_ready_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_WORD_END);
        w_busy_nxt     = (w_state_nxt != ST_IDLE);
        w_sclk_nxt     = r_sclk;
        w_ssel_nxt     = r_ssel;
        w_mosi_nxt     = r_mosi;
        case (r_state)
            ST_IDLE, ST_WORD_END: begin
                if (w_accept) begin
                    w_tx_shift_nxt = txData;
                    w_mosi_nxt     = w_load_bit;
                    w_ssel_nxt     = 1'b0;
                    w_bit_cnt_nxt  = '0;
                end
            end
            ST_SETUP: begin
                if (w_tick) begin
                    w_sclk_nxt     = 1'b1;
                    w_rx_shift_nxt = w_rx_shifted;
                    w_bit_cnt_nxt  = r_bit_cnt + BIT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    if (!r_sclk) begin
                        w_sclk_nxt     = 1'b1;
                        w_rx_shift_nxt = w_rx_shifted;
                        w_bit_cnt_nxt  = r_bit_cnt + BIT_W'(1);
                    end else begin
                        w_sclk_nxt = 1'b0;
                        if (r_bit_cnt == BIT_LAST) begin
                            w_rx_data_nxt  = r_rx_shift;
                            w_rx_valid_nxt = 1'b1;
                        end else begin
                            w_tx_shift_nxt = w_tx_shifted;
                            w_mosi_nxt     = w_next_bit;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (w_tick) begin
                    w_ssel_nxt = 1'b1;
                    w_mosi_nxt = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_sclk     <= 1'b0;
            r_ssel     <= 1'b1;
            r_mosi     <= 1'b0;
        end else begin
            r_div_cnt  <= w_div_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_tx_ready <= w_tx_ready_nxt;
            r_busy     <= w_busy_nxt;
            r_sclk     <= w_sclk_nxt;
            r_ssel     <= w_ssel_nxt;
            r_mosi     <= w_mosi_nxt;
        end
    end

    assign txReady = r_tx_ready;
    assign rxData  = r_rx_data;
    assign rxValid = r_rx_valid;
    assign busy    = r_busy;
    assign sclk    = r_sclk;
    assign ssel    = r_ssel;
    assign mosi    = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench for spi_master (DATA_WIDTH=8, CLK_DIV=2).
module tb_spi_master;

    localparam int unsigned DW = 8;
    localparam int unsigned CD = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] txData = '0;
    logic          txValid = 1'b0;
    logic          txReady;
    logic [DW-1:0] rxData;
    logic          rxValid;
    logic          busy;
    logic          sclk;
    logic          ssel;
    logic          mosi;
    logic          miso;
    int            miso_mode = 0;   // 0 loopback, 1 tied high, 2 tied low

    assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1);

    spi_master #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
        .clk(clk), .reset(reset), .txData(txData), .txValid(txValid),
        .txReady(txReady), .rxData(rxData), .rxValid(rxValid), .busy(busy),
        .sclk(sclk), .ssel(ssel), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    int n_vectors = 0;
    int n_miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboards filled at accept time.
    bit            mosi_q[$];
    logic [DW-1:0] rx_q[$];

    int cyc = 0;
    int acc_cyc = 0, ssel_fall = 0, ssel_rise = 0, last_rise = 0, last_fall = 0;
    int last_rxv = 0, ready_rise = 0, rise_cnt = 0, rxv_n = 0, ssel_rise_n = 0;
    bit first_word = 0, in_burst = 0;
    bit prev_sclk = 0, prev_ssel = 1, prev_rdy = 1;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Pin monitor: timing, mosi bit order and received words.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            rise_cnt   = 0;
            first_word = 0;
            in_burst   = 0;
        end else begin
            if (prev_ssel && !ssel) begin
                ssel_fall  = cyc;
                first_word = 1;
                in_burst   = 0;
            end
            if (!prev_ssel && ssel) begin
                ssel_rise = cyc;
                ssel_rise_n++;
                in_burst = 0;
            end
            if (!prev_rdy && txReady) ready_rise = cyc;
            if (!prev_sclk && sclk) begin
                if (rise_cnt == 0) begin
                    if (in_burst) check("burst_gap", cyc - last_fall, 1 + CD);
                    else          check("ssel_to_rise", cyc - ssel_fall, CD);
                end else begin
                    check("sclk_period", cyc - last_rise, 2 * CD);
                end
                last_rise = cyc;
                rise_cnt++;
                if (mosi_q.size() == 0) check("mosi_unexpected", 1, 0);
                else                    check("mosi_bit", {31'b0, mosi}, {31'b0, mosi_q.pop_front()});
            end
            if (prev_sclk && !sclk) last_fall = cyc;
            if (rxValid) begin
                rxv_n++;
                last_rxv = cyc;
                check("rise_count", rise_cnt, DW);
                if (first_word) check("ssel_to_rxvalid", cyc - ssel_fall, 2 * CD * DW);
                if (rx_q.size() == 0) check("rx_unexpected", 1, 0);
                else                  check("rx_data", {24'b0, rxData}, {24'b0, rx_q.pop_front()});
                rise_cnt   = 0;
                first_word = 0;
                in_burst   = 1;
            end
        end
        prev_sclk = sclk;
        prev_ssel = ssel;
        prev_rdy  = txReady;
    end

    task automatic send_word(input logic [DW-1:0] tx, input logic [DW-1:0] rx_exp, input bit last);
        int waited = 0;
        txData  = tx;
        txValid = 1'b1;
        while (!txReady && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("accept_reached", {31'b0, txReady}, 1);
        acc_cyc = cyc;
        for (int i = 0; i < DW; i++) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
            mosi_q.push_back(tx[i]);
`else
            mosi_q.push_back(tx[DW-1-i]);
`endif
        end
        rx_q.push_back(rx_exp);
        @(posedge clk);
        @(negedge clk);
        if (last) txValid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            #2;
            if (!busy && txReady) done = 1;
        end
        check("idle_reached", {31'b0, done}, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rxv0, sr0;
        bit hit;
        repeat (2) @(negedge clk);
        check("reset_pins", {26'b0, sclk, ssel, mosi, txReady, busy, rxValid}, 32'b010100);
        check("reset_rxdata", {24'b0, rxData}, 0);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_pins", {26'b0, sclk, ssel, mosi, txReady, busy, rxValid}, 32'b010100);
        end

        // Single word, loopback.
        miso_mode = 0;
        send_word(8'hA5, 8'hA5, 1);
        wait_idle();
        check("accept_to_ssel", ssel_fall - acc_cyc, 1);
        check("hold_time", ssel_rise - last_rxv, 1 + CD);
        check("desel_time", ready_rise - ssel_rise, CD);
        check("idle_mosi", {31'b0, mosi}, 0);

        // Burst of three words with txValid held.
        rxv0 = rxv_n;
        sr0  = ssel_rise_n;
        send_word(8'h3C, 8'h3C, 0);
        send_word(8'hFF, 8'hFF, 0);
        send_word(8'h00, 8'h00, 1);
        wait_idle();
        check("burst_rxvalids", rxv_n - rxv0, 3);
        check("burst_ssel_rises", ssel_rise_n - sr0, 1);

        // Tied miso.
        miso_mode = 1;
        send_word(8'h00, 8'hFF, 1);
        wait_idle();
        miso_mode = 2;
        send_word(8'hFF, 8'h00, 1);
        wait_idle();
        miso_mode = 0;

        // Reset on the 4th sclk rise.
        rxv0 = rxv_n;
        send_word(8'h5A, 8'h5A, 1);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            #2;
            if (rise_cnt == 4) hit = 1;
        end
        check("fourth_rise_seen", {31'b0, hit}, 1);
        reset = 1'b1;
        #1;
        check("abort_ssel", {31'b0, ssel}, 1);
        check("abort_sclk", {31'b0, sclk}, 0);
        mosi_q.delete();
        rx_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_rxvalid", rxv_n - rxv0, 0);
        send_word(8'h81, 8'h81, 1);
        wait_idle();
        check("post_reset_rxvalid", rxv_n - rxv0, 1);

        // Bit-order word.
        send_word(8'h01, 8'h01, 1);
        wait_idle();
        check("final_rxdata", {24'b0, rxData}, 32'h01);
        check("mosi_q_empty", mosi_q.size(), 0);
        check("rx_q_empty", rx_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
